alu_control_mdu: RTL
====================

// Module: alu_control_mdu
// PURPOSE
//  Parametrised next-generation ALU control unit for the MIPS core. Decodes aluop/funct to an
//  ALU control code for single-cycle ops, and sequences multi-cycle MULT/MULTU/DIV/DIVU on an
//  internal iterative HI/LO unit. Stalls the pipeline for MFHI/MFLO until HI/LO are ready.
//  Sits in EX, beside the ALU; the ALU consumes alucnt and the hazard unit consumes stall.
// PARAMETERS
//  WIDTH     32  operand/HI/LO width; WIDTH >= 4
//  ALUOP_W   3   aluop width
//  FUNCT_W   6   funct width
//  ALUCNT_W  4   alucnt width
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         reset, asynchronous assert, active-low
//  valid      in   1         EX holds a real instruction this cycle
//  flush      in   1         abort any in-flight mult/div
//  aluop      in   ALUOP_W   0 add, 1 sub, 2 R-type(funct), 3 and, 4 or, 5 slt, 6 xor, 7 lui
//  funct      in   FUNCT_W   R-type function field
//  op_a       in   WIDTH     rs value (dividend / multiplicand)
//  op_b       in   WIDTH     rt value (divisor / multiplier)
//  alucnt     out  ALUCNT_W  0 and, 1 or, 2 add, 3 xor, 4 nor, 5 sll, 6 sub, 7 slt, 8 sltu,
//                            9 srl, 10 sra, 11 lui, 15 none
//  stall      out  1         hold IF/ID/EX this cycle
//  busy       out  1         mult/div in flight
//  done       out  1         one-cycle pulse; HI/LO updated at this edge
//  div_zero   out  1         sticky flag for the last DIV/DIVU; cleared by next mult/div start
//  hilo_rd    out  WIDTH     HI for MFHI, LO for MFLO, else 0
// BEHAVIOUR
//  - Reset: alucnt=15 (comb of reset inputs irrelevant), stall=0, busy=0, done=0, div_zero=0,
//    HI=LO=0, state=IDLE. Reset mid-operation discards the op; HI/LO=0.
//  - alucnt is combinational. aluop 2 maps funct: 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor,
//    27 nor, 2A slt, 2B sltu, 00 sll, 02 srl, 03 sra. Mult/div/MFHI/MFLO/unknown funct give 15.
//  - States: IDLE -> RUN (exactly WIDTH cycles, shift-add or restoring divide per cycle)
//    -> FIX (sign correction, one cycle) -> IDLE.
//  - Start: IDLE & valid & aluop==2 & funct in {18,19,1A,1B}; operands latched at that edge.
//    Start cycle does not stall, so the issuing instruction leaves EX.
//  - Signed ops use magnitudes in RUN; FIX negates product, quotient if signs differ, and
//    remainder if dividend < 0. Ordering: HI=remainder, LO=quotient; HI:LO=product.
//  - DIV/DIVU with op_b==0: skip RUN, go to FIX; HI=op_a, LO=all ones, div_zero=1.
//  - HI/LO written at the FIX->IDLE edge; done=1 during FIX. Latency start->HI/LO visible = WIDTH+2.
//  - stall=1 when valid & (MFHI/MFLO or new mult/div) & state!=IDLE. In the FIX cycle the
//    result is forwarded: MFHI/MFLO in FIX return the new value with stall=0.
//  - busy = (state!=IDLE).
//  - flush: state->IDLE next edge; HI/LO unchanged; done not pulsed. Flush wins over a
//    same-cycle start.
//  - Only one op in flight; new mult/div while busy is stalled, not queued.
//  - All arithmetic modulo 2^WIDTH per half; no overflow traps.
// STRUCTURE
//  - Package alu_ctrl_pkg: aluop codes, funct codes, alucnt codes, state enum.
//  - Sub-module mdu_iter_core: RUN/FIX datapath (accumulator, shift regs, iteration counter),
//    started and flushed by this block. The decode logic and stall logic stay in the top.
// TESTING (WIDTH=8 bench plus a WIDTH=32 smoke run)
//  1. aluop=2 funct=22 -> alucnt=6; aluop=4 funct=01 -> alucnt=1; aluop=2 funct=3F -> 15.
//  2. MULT a=3 b=-5 (0xFB) -> done at start+9, then HI=0xFF LO=0xF1; MULTU same -> HI=0x02 LO=0xF1.
//  3. DIV a=-7 b=2 -> LO=0xFD HI=0xFF; DIVU a=7 b=0 -> done at start+1, HI=0x07 LO=0xFF, div_zero=1.
//  4. MFLO issued at start+1 -> stall=1 through start+8, stall=0 in FIX, hilo_rd=new LO.
//  5. flush at start+4 -> busy=0 next cycle, no done pulse, HI/LO keep old values;
//     flush+start in same cycle -> stays IDLE.
//  6. rst_n low at start+3 -> busy=0, HI=LO=0 immediately; a new MULT after release -> correct result.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared codes for the EX-stage ALU control / mult-div unit: aluop, funct, alucnt and MDU state.
package alu_ctrl_pkg;

    localparam int unsigned AOP_ADD   = 0;
    localparam int unsigned AOP_SUB   = 1;
    localparam int unsigned AOP_RTYPE = 2;
    localparam int unsigned AOP_AND   = 3;
    localparam int unsigned AOP_OR    = 4;
    localparam int unsigned AOP_SLT   = 5;
    localparam int unsigned AOP_XOR   = 6;
    localparam int unsigned AOP_LUI   = 7;

    localparam int unsigned F_SLL   = 'h00;
    localparam int unsigned F_SRL   = 'h02;
    localparam int unsigned F_SRA   = 'h03;
    localparam int unsigned F_MFHI  = 'h10;
    localparam int unsigned F_MFLO  = 'h12;
    localparam int unsigned F_MULT  = 'h18;
    localparam int unsigned F_MULTU = 'h19;
    localparam int unsigned F_DIV   = 'h1A;
    localparam int unsigned F_DIVU  = 'h1B;
    localparam int unsigned F_ADD   = 'h20;
    localparam int unsigned F_ADDU  = 'h21;
    localparam int unsigned F_SUB   = 'h22;
    localparam int unsigned F_SUBU  = 'h23;
    localparam int unsigned F_AND   = 'h24;
    localparam int unsigned F_OR    = 'h25;
    localparam int unsigned F_XOR   = 'h26;
    localparam int unsigned F_NOR   = 'h27;
    localparam int unsigned F_SLT   = 'h2A;
    localparam int unsigned F_SLTU  = 'h2B;

    localparam int unsigned AC_AND  = 0;
    localparam int unsigned AC_OR   = 1;
    localparam int unsigned AC_ADD  = 2;
    localparam int unsigned AC_XOR  = 3;
    localparam int unsigned AC_NOR  = 4;
    localparam int unsigned AC_SLL  = 5;
    localparam int unsigned AC_SUB  = 6;
    localparam int unsigned AC_SLT  = 7;
    localparam int unsigned AC_SLTU = 8;
    localparam int unsigned AC_SRL  = 9;
    localparam int unsigned AC_SRA  = 10;
    localparam int unsigned AC_LUI  = 11;
    localparam int unsigned AC_NONE = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide engine: WIDTH shift-add or restoring-divide steps on magnitudes,
// then one sign-fix cycle whose corrected result is presented on res_hi/res_lo.
module mdu_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output mdu_state_e       state,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_dz
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    mdu_state_e          state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    sr;
    logic [WIDTH-1:0]    md;
    logic                div_r;
    logic                dz_r;
    logic                neg_p;
    logic                neg_r;

    logic                sa;
    logic                sb;
    logic [WIDTH-1:0]    ma;
    logic [WIDTH-1:0]    mb;
    logic                div_by_zero;
    logic                last;
    logic [WIDTH:0]      add_sum;
    logic [WIDTH:0]      sh;
    logic [WIDTH-1:0]    acc_step;
    logic [WIDTH-1:0]    sr_step;
    logic [2*WIDTH-1:0]  prod;

    assign sa          = is_signed & a[WIDTH-1];
    assign sb          = is_signed & b[WIDTH-1];
    assign ma          = sa ? -a : a;
    assign mb          = sb ? -b : b;
    assign div_by_zero = is_div & (b == '0);
    assign last        = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !flush) state_nxt = div_by_zero ? S_FIX : S_RUN;
            S_RUN: begin
                if (flush)     state_nxt = S_IDLE;
                else if (last) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration: divide shifts the dividend into the partial remainder, multiply shifts right.
    always_comb begin
        add_sum  = {1'b0, acc} + {1'b0, md};
        sh       = {acc, sr[WIDTH-1]};
        acc_step = acc;
        sr_step  = sr;
        if (div_r) begin
            if (sh >= {1'b0, md}) begin
                acc_step = sh[WIDTH-1:0] - md;
                sr_step  = {sr[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = sh[WIDTH-1:0];
                sr_step  = {sr[WIDTH-2:0], 1'b0};
            end
        end else if (sr[0]) begin
            acc_step = add_sum[WIDTH:1];
            sr_step  = {add_sum[0], sr[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[WIDTH-1:1]};
            sr_step  = {acc[0], sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            sr    <= '0;
            md    <= '0;
            div_r <= 1'b0;
            dz_r  <= 1'b0;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == S_IDLE && start && !flush) begin
            cnt   <= '0;
            div_r <= is_div;
            dz_r  <= div_by_zero;
            neg_p <= sa ^ sb;
            neg_r <= sa;
            md    <= is_div ? mb : ma;
            if (div_by_zero) begin
                acc <= a;
                sr  <= '1;
            end else begin
                acc <= '0;
                sr  <= is_div ? ma : mb;
            end
        end else if (state == S_RUN) begin
            acc <= acc_step;
            sr  <= sr_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sign correction of the raw magnitude result, valid while in FIX.
    always_comb begin
        res_hi = acc;
        res_lo = sr;
        res_dz = dz_r;
        prod   = {acc, sr};
        if (!dz_r) begin
            if (div_r) begin
                res_lo = neg_p ? -sr : sr;
                res_hi = neg_r ? -acc : acc;
            end else begin
                if (neg_p) prod = -{acc, sr};
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control: aluop/funct decode to alucnt, HI/LO ownership, mult/div issue and
// MFHI/MFLO interlock around the iterative core.
module alu_control_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUCNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic                flush,
    input  logic [ALUOP_W-1:0]  aluop,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    output logic [ALUCNT_W-1:0] alucnt,
    output logic                stall,
    output logic                busy,
    output logic                done,
    output logic                div_zero,
    output logic [WIDTH-1:0]    hilo_rd
);

    mdu_state_e       state;
    logic             is_r;
    logic             f_mult;
    logic             f_multu;
    logic             f_div;
    logic             f_divu;
    logic             f_muldiv;
    logic             f_mfhi;
    logic             f_mflo;
    logic             start;
    logic             commit;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_dz;
    logic [WIDTH-1:0] hi_view;
    logic [WIDTH-1:0] lo_view;

    assign is_r     = (aluop == ALUOP_W'(AOP_RTYPE));
    assign f_mult   = is_r & (funct == FUNCT_W'(F_MULT));
    assign f_multu  = is_r & (funct == FUNCT_W'(F_MULTU));
    assign f_div    = is_r & (funct == FUNCT_W'(F_DIV));
    assign f_divu   = is_r & (funct == FUNCT_W'(F_DIVU));
    assign f_muldiv = f_mult | f_multu | f_div | f_divu;
    assign f_mfhi   = is_r & (funct == FUNCT_W'(F_MFHI));
    assign f_mflo   = is_r & (funct == FUNCT_W'(F_MFLO));

    assign start  = valid & f_muldiv & (state == S_IDLE) & ~flush;
    assign commit = (state == S_FIX) & ~flush;
    assign busy   = (state != S_IDLE);
    assign done   = commit;

    // MFHI/MFLO are released in FIX because the fresh result is forwarded that cycle.
    assign stall = valid & ((f_muldiv & (state != S_IDLE)) | ((f_mfhi | f_mflo) & (state == S_RUN)));

    always_comb begin
        alucnt = ALUCNT_W'(AC_NONE);
        case (32'(aluop))
            AOP_ADD: alucnt = ALUCNT_W'(AC_ADD);
            AOP_SUB: alucnt = ALUCNT_W'(AC_SUB);
            AOP_AND: alucnt = ALUCNT_W'(AC_AND);
            AOP_OR:  alucnt = ALUCNT_W'(AC_OR);
            AOP_SLT: alucnt = ALUCNT_W'(AC_SLT);
            AOP_XOR: alucnt = ALUCNT_W'(AC_XOR);
            AOP_LUI: alucnt = ALUCNT_W'(AC_LUI);
            AOP_RTYPE: begin
                case (32'(funct))
                    F_ADD, F_ADDU: alucnt = ALUCNT_W'(AC_ADD);
                    F_SUB, F_SUBU: alucnt = ALUCNT_W'(AC_SUB);
                    F_AND:         alucnt = ALUCNT_W'(AC_AND);
                    F_OR:          alucnt = ALUCNT_W'(AC_OR);
                    F_XOR:         alucnt = ALUCNT_W'(AC_XOR);
                    F_NOR:         alucnt = ALUCNT_W'(AC_NOR);
                    F_SLT:         alucnt = ALUCNT_W'(AC_SLT);
                    F_SLTU:        alucnt = ALUCNT_W'(AC_SLTU);
                    F_SLL:         alucnt = ALUCNT_W'(AC_SLL);
                    F_SRL:         alucnt = ALUCNT_W'(AC_SRL);
                    F_SRA:         alucnt = ALUCNT_W'(AC_SRA);
                    default:       alucnt = ALUCNT_W'(AC_NONE);
                endcase
            end
            default: alucnt = ALUCNT_W'(AC_NONE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (start) begin
            div_zero <= 1'b0;
        end else if (commit) begin
            hi       <= res_hi;
            lo       <= res_lo;
            div_zero <= res_dz;
        end
    end

    assign hi_view = commit ? res_hi : hi;
    assign lo_view = commit ? res_lo : lo;

    always_comb begin
        hilo_rd = '0;
        if (valid && f_mfhi)      hilo_rd = hi_view;
        else if (valid && f_mflo) hilo_rd = lo_view;
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .is_div    (f_div | f_divu),
        .is_signed (f_mult | f_div),
        .a         (op_a),
        .b         (op_b),
        .state     (state),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .res_dz    (res_dz)
    );

endmodule
